// File: rtl/gray_counter.sv
// gray_counter: up/down Gray-code counter with synchronous binary load and a wrap pulse.
// The count is kept in binary, and the Gray output is registered from the next binary value.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);
    logic [WIDTH-1:0] b_q, b_d, gray_q;
    logic             wrap_q, wrap_d;

    always_comb begin
        b_d    = load ? load_bin : en ? (up ? b_q + WIDTH'(1) : b_q - WIDTH'(1)) : b_q;
        wrap_d = !load && en && (up ? &b_q : ~|b_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_q    <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            gray_q <= b_d ^ (b_d >> 1);
            wrap_q <= wrap_d;
        end
    end

    assign gray = gray_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed checks of the 4-bit Gray counter, including a bench-side Gray-to-binary chain check.
module tb_gray_counter;
    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [3:0] load_bin, gray, prev;
    logic       wrap;
    int         checks = 0;
    int         errors = 0;

    gray_counter #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_bin(load_bin), .gray(gray), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] r;
        r[3] = g[3];
        for (int k = 2; k >= 0; k--) r[k] = r[k+1] ^ g[k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        edge1();
        reset = 1'b0;
    endtask

    logic [3:0] up_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                               4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0;
        #2;
        chk("reset_gray_noclk", 32'(gray), 0);
        chk("reset_wrap_noclk", 32'(wrap), 0);
        edge1();
        reset = 1'b0;
        chk("reset_gray", 32'(gray), 0);
        en = 1'b1; up = 1'b1;
        prev = gray;
        for (int i = 0; i < 16; i++) begin
            edge1();
            chk($sformatf("up_gray%0d", i), 32'(gray), 32'(up_seq[i]));
            chk($sformatf("up_wrap%0d", i), 32'(wrap), (i == 15) ? 1 : 0);
            chk($sformatf("up_onebit%0d", i), $countones(prev ^ gray), 1);
            prev = gray;
        end

        do_reset();
        en = 1'b1; up = 1'b0;
        edge1();
        chk("down_wrap_gray", 32'(gray), 32'b1000);
        chk("down_wrap_wrap", 32'(wrap), 1);
        edge1();
        chk("down2_gray", 32'(gray), 32'b1001);
        chk("down2_wrap", 32'(wrap), 0);
        up = 1'b1;
        edge1();
        chk("dirchg_gray", 32'(gray), 32'b1000);

        load = 1'b1; load_bin = 4'b0110; en = 1'b1; up = 1'b1;
        edge1();
        chk("load_gray", 32'(gray), 32'b0101);
        chk("load_wrap", 32'(wrap), 0);
        load = 1'b0;
        edge1();
        chk("after_load_gray", 32'(gray), 32'b0100);

        load = 1'b1; load_bin = 4'b1111; en = 1'b1; up = 1'b1;
        edge1();
        chk("load_ones_wrap", 32'(wrap), 0);
        chk("load_ones_gray", 32'(gray), 32'b1000);

        load = 1'b1; load_bin = 4'd9; en = 1'b0;
        edge1();
        chk("load9_gray", 32'(gray), 32'b1101);
        edge1();
        chk("reload_same_gray", 32'(gray), 32'b1101);
        chk("reload_same_wrap", 32'(wrap), 0);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge1();
            chk($sformatf("hold_gray%0d", i), 32'(gray), 32'b1101);
            chk($sformatf("hold_wrap%0d", i), 32'(wrap), 0);
        end

        load = 1'b1; load_bin = 4'd10;
        edge1();
        load = 1'b0; en = 1'b1; up = 1'b1;
        edge1();
        chk("pre_async_gray", 32'(gray), 32'b1110);
        #3;
        reset = 1'b1;
        #1;
        chk("async_gray", 32'(gray), 0);
        chk("async_wrap", 32'(wrap), 0);
        edge1();
        reset = 1'b0;
        edge1();
        chk("resume_gray", 32'(gray), 32'b0001);

        en = 1'b1; up = 1'b0; load = 1'b1; load_bin = 4'd0;
        edge1();
        load = 1'b0;
        edge1();
        chk("wrap_before_abort", 32'(wrap), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_wrap_clear", 32'(wrap), 0);
        chk("async_gray_clear", 32'(gray), 0);
        edge1();
        reset = 1'b0; en = 1'b0;
        edge1();
        chk("no_residual_wrap", 32'(wrap), 0);
        chk("no_residual_gray", 32'(gray), 0);

        load = 1'b1; load_bin = 4'd0;
        edge1();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            edge1();
            chk($sformatf("chain_bin%0d", i), 32'(g2b(gray)), i % 16);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
